// File: rtl/alu_md_pkg.sv
// Shared types for the alu_md execute unit: opcode and iteration-state enums,
// plus a helper that picks out the multi-cycle opcodes.
package alu_md_pkg;
  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 4'd0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_RSV,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_e;

  function automatic logic is_md_op(input alu_op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction
endpackage

// File: rtl/alu_md_if.sv
// Issue/result bundle between the EX stage and alu_md.
interface alu_md_if import alu_md_pkg::*; #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  alu_op_e          op;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             zero_flag;
  logic             exp_overflow;
  logic             div_by_zero;
  logic             illegal_op;

  modport master (
    output flush, in_valid, op, data1, data2,
    input  in_ready, out_valid, result, hi, lo, zero_flag, exp_overflow, div_by_zero, illegal_op
  );
  modport slave (
    input  flush, in_valid, op, data1, data2,
    output in_ready, out_valid, result, hi, lo, zero_flag, exp_overflow, div_by_zero, illegal_op
  );
endinterface

// File: rtl/alu_md_iter.sv
// Shared 1-bit/cycle engine: shift-add multiply or restoring divide on unsigned
// magnitudes. nxt_hi/nxt_lo expose the step in flight so the last one lands with done.
module alu_md_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             start,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_r, lo_r, b_r;
  logic [CW-1:0]    cnt;
  logic             mode_r;
  logic [WIDTH:0]   sum, shifted;
  logic             ge;

  // hi holds partial product (mul) or partial remainder (div); lo holds multiplier / quotient
  always_comb begin
    sum     = {1'b0, hi_r} + {1'b0, b_r};
    shifted = {hi_r, lo_r[WIDTH-1]};
    ge      = shifted >= {1'b0, b_r};
    if (mode_r) begin
      nxt_hi = ge ? (shifted[WIDTH-1:0] - b_r) : shifted[WIDTH-1:0];
      nxt_lo = {lo_r[WIDTH-2:0], ge};
    end else if (lo_r[0]) begin
      {nxt_hi, nxt_lo} = {sum, lo_r[WIDTH-1:1]};
    end else begin
      {nxt_hi, nxt_lo} = {1'b0, hi_r, lo_r[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r   <= '0;
      lo_r   <= '0;
      b_r    <= '0;
      cnt    <= '0;
      mode_r <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      hi_r   <= '0;
      lo_r   <= a;
      b_r    <= b;
      mode_r <= div_mode;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      hi_r <= nxt_hi;
      lo_r <= nxt_lo;
      cnt  <= cnt - CW'(1);
    end
  end

  assign last = (cnt == CW'(1));
endmodule

// File: rtl/alu_md.sv
// MIPS EX-stage execute unit: single-cycle ALU ops plus iterative mul/div with HI/LO.
// Build macro ALU_MD_DIV_EN enables the divider; without it DIV/DIVU flag illegal_op.
module alu_md import alu_md_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_md_if.slave  bus
);
`ifdef ALU_MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  md_state_e        state, state_nxt;
  logic             in_ready, accept, is_div, sgn, s1, s2, b_zero, start_md, last;
  logic [WIDTH-1:0] mag1, mag2, it_hi, it_lo, md_hi, md_lo, sc_result;
  logic [WIDTH:0]   add_s, sub_s;
  logic             sc_ovf;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic             neg_lo, neg_hi;
  logic [WIDTH-1:0] hi_q, lo_q, result_q;
  logic             vld_q, sc_q, zf_q, ovf_q, dbz_q, ill_q;

  assign accept   = bus.in_valid & in_ready;
  assign is_div   = bus.op inside {OP_DIV, OP_DIVU};
  assign sgn      = bus.op inside {OP_MULT, OP_DIV};
  assign s1       = sgn & bus.data1[WIDTH-1];
  assign s2       = sgn & bus.data2[WIDTH-1];
  assign mag1     = s1 ? -bus.data1 : bus.data1;
  assign mag2     = s2 ? -bus.data2 : bus.data2;
  assign b_zero   = (bus.data2 == '0);
  // divide-by-zero and disabled-divider cases retire through the single-cycle path
  assign start_md = accept & is_md_op(bus.op) & ~(is_div & (~DIV_EN | b_zero));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~bus.flush;
        if (start_md) state_nxt = is_div ? DIV : MUL;
      end
      MUL, DIV: if (bus.flush || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  alu_md_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .abort   (bus.flush),
    .start   (start_md),
    .div_mode(is_div),
    .a       (mag1),
    .b       (mag2),
    .last    (last),
    .nxt_hi  (it_hi),
    .nxt_lo  (it_lo)
  );

  // restore signs: product as a whole, quotient by s1^s2, remainder follows dividend
  always_comb begin
    prod     = {it_hi, it_lo};
    prod_fix = neg_lo ? -prod : prod;
    if (state == DIV) begin
      md_hi = neg_hi ? -it_hi : it_hi;
      md_lo = neg_lo ? -it_lo : it_lo;
    end else begin
      md_hi = prod_fix[2*WIDTH-1:WIDTH];
      md_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_comb begin
    add_s     = {bus.data1[WIDTH-1], bus.data1} + {bus.data2[WIDTH-1], bus.data2};
    sub_s     = {bus.data1[WIDTH-1], bus.data1} - {bus.data2[WIDTH-1], bus.data2};
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (bus.op)
      OP_ADD:  begin sc_result = add_s[WIDTH-1:0]; sc_ovf = add_s[WIDTH] ^ add_s[WIDTH-1]; end
      OP_SUB:  begin sc_result = sub_s[WIDTH-1:0]; sc_ovf = sub_s[WIDTH] ^ sub_s[WIDTH-1]; end
      OP_AND:  sc_result = bus.data1 & bus.data2;
      OP_OR:   sc_result = bus.data1 | bus.data2;
      OP_XOR:  sc_result = bus.data1 ^ bus.data2;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(bus.data1) < $signed(bus.data2)};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, bus.data1 < bus.data2};
      OP_MFHI: sc_result = hi_q;
      OP_MFLO: sc_result = lo_q;
      default: sc_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0; lo_q <= '0; result_q <= '0;
      vld_q <= 1'b0; sc_q <= 1'b0; zf_q <= 1'b0; ovf_q <= 1'b0; dbz_q <= 1'b0; ill_q <= 1'b0;
      neg_lo <= 1'b0; neg_hi <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      sc_q  <= 1'b0;
      if (accept) begin
        result_q <= sc_result;
        zf_q     <= (bus.data1 == bus.data2);
        ovf_q    <= sc_ovf;
        dbz_q    <= is_div & DIV_EN & b_zero;
        ill_q    <= is_div & ~DIV_EN;
        vld_q    <= ~start_md;
        sc_q     <= ~start_md;
        if (bus.op == OP_MTHI) hi_q <= bus.data1;
        if (bus.op == OP_MTLO) lo_q <= bus.data1;
        if (start_md) begin
          neg_lo <= s1 ^ s2;
          neg_hi <= is_div ? s1 : (s1 ^ s2);
        end
      end else if (state != IDLE && last && !bus.flush) begin
        vld_q    <= 1'b1;
        result_q <= md_lo;
        hi_q     <= md_hi;
        lo_q     <= md_lo;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = vld_q & ~(bus.flush & sc_q);
  assign bus.result       = result_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.zero_flag    = zf_q;
  assign bus.exp_overflow = ovf_q;
  assign bus.div_by_zero  = dbz_q;
  assign bus.illegal_op   = ill_q;
endmodule

// File: tb/tb_alu_md.sv
// Randomized + directed bench for alu_md against a plain-arithmetic HI/LO model.
module tb_alu_md;
  import alu_md_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_md_if #(.WIDTH(W)) bus();
  alu_md #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] result, hi, lo;
    logic [3:0]  flags;   // {zero, overflow, div_by_zero, illegal}
    int          lat;
    int          rdy_low;
  } res_t;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  function automatic res_t model(input alu_op_e op, input logic [31:0] d1, d2, mhi, mlo);
    res_t r;
    longint s, q, rm;
    logic [63:0] p;
    r = '{default: 0};
    r.hi = mhi; r.lo = mlo; r.lat = 1;
    r.flags[3] = (d1 == d2);
    case (op)
      OP_ADD, OP_SUB: begin
        s = (op == OP_ADD) ? longint'($signed(d1)) + longint'($signed(d2))
                           : longint'($signed(d1)) - longint'($signed(d2));
        r.result = s[31:0];
        r.flags[2] = (s != longint'($signed(s[31:0])));
      end
      OP_AND:  r.result = d1 & d2;
      OP_OR:   r.result = d1 | d2;
      OP_XOR:  r.result = d1 ^ d2;
      OP_SLT:  r.result = ($signed(d1) < $signed(d2)) ? 32'd1 : 32'd0;
      OP_SLTU: r.result = (d1 < d2) ? 32'd1 : 32'd0;
      OP_MULT, OP_MULTU: begin
        if (op == OP_MULT) begin s = longint'($signed(d1)) * longint'($signed(d2)); p = s; end
        else p = {32'b0, d1} * {32'b0, d2};
        r.hi = p[63:32]; r.lo = p[31:0]; r.result = p[31:0]; r.lat = W + 1;
      end
      OP_DIV, OP_DIVU: begin
`ifdef ALU_MD_DIV_EN
        if (d2 == 0) r.flags[1] = 1'b1;
        else begin
          if (op == OP_DIV) begin
            q = longint'($signed(d1)) / longint'($signed(d2));
            rm = longint'($signed(d1)) % longint'($signed(d2));
          end else begin
            q = longint'({32'b0, d1}) / longint'({32'b0, d2});
            rm = longint'({32'b0, d1}) % longint'({32'b0, d2});
          end
          r.lo = q[31:0]; r.hi = rm[31:0]; r.result = q[31:0]; r.lat = W + 1;
        end
`else
        r.flags[0] = 1'b1;
`endif
      end
      OP_MFHI: r.result = mhi;
      OP_MFLO: r.result = mlo;
      OP_MTHI: r.hi = d1;
      OP_MTLO: r.lo = d1;
      default: r.result = '0;
    endcase
    r.rdy_low = r.lat - 1;
    return r;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from idle and capture the first result pulse (lat stays 0 without a pulse).
  task automatic run_op(input alu_op_e op, input logic [31:0] d1, d2, output res_t o);
    int w;
    o = '{default: 0};
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    bus.in_valid = 1'b1; bus.op = op; bus.data1 = d1; bus.data2 = d2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.out_valid) begin
        o.lat = k; o.result = bus.result; o.hi = bus.hi; o.lo = bus.lo;
        o.flags = {bus.zero_flag, bus.exp_overflow, bus.div_by_zero, bus.illegal_op};
        break;
      end
      if (!bus.in_ready) o.rdy_low++;
    end
    if (o.lat == 0) begin o.hi = bus.hi; o.lo = bus.lo; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.result !== '0) begin
      n_bad++; $display("FAIL reset_out: got vld=%b res=%h want 0/0", bus.out_valid, bus.result);
    end
    n_cmp++;
    if (bus.hi !== '0 || bus.lo !== '0) begin
      n_bad++; $display("FAIL reset_hilo: got %h/%h want 0/0", bus.hi, bus.lo);
    end
    n_cmp++;
    if ({bus.zero_flag, bus.exp_overflow, bus.div_by_zero, bus.illegal_op} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000",
        {bus.zero_flag, bus.exp_overflow, bus.div_by_zero, bus.illegal_op});
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    alu_op_e     ops[12] = '{OP_ADD, OP_MULT, OP_MULTU, OP_DIV, OP_DIV, OP_MTHI, OP_MTLO,
                             OP_DIVU, OP_SLT, OP_SLTU, OP_MFHI, OP_RSV};
    logic [31:0] a[12] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                           32'h8000_0000, 32'h1234, 32'h5678, 32'h7, 32'hFFFF_FFFF,
                           32'hFFFF_FFFF, 32'h0, 32'h55};
    logic [31:0] b[12] = '{32'h1, 32'h2, 32'h2, 32'h2, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,
                           32'h1, 32'h1, 32'h0, 32'h55};
    res_t e, o;
    for (int i = 0; i < 12; i++) begin
      e = model(ops[i], a[i], b[i], m_hi, m_lo);
      run_op(ops[i], a[i], b[i], o);
      n_cmp++;
      if (o.lat !== e.lat || o.rdy_low !== e.rdy_low) begin
        n_bad++; $display("FAIL dir%0d_timing: got lat=%0d rdy_low=%0d want %0d/%0d",
                          i, o.lat, o.rdy_low, e.lat, e.rdy_low);
      end
      n_cmp++;
      if (o.result !== e.result) begin
        n_bad++; $display("FAIL dir%0d_result: got %h want %h", i, o.result, e.result);
      end
      n_cmp++;
      if (o.hi !== e.hi || o.lo !== e.lo) begin
        n_bad++; $display("FAIL dir%0d_hilo: got %h/%h want %h/%h", i, o.hi, o.lo, e.hi, e.lo);
      end
      n_cmp++;
      if (o.flags !== e.flags) begin
        n_bad++; $display("FAIL dir%0d_flags: got %b want %b", i, o.flags, e.flags);
      end
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic test_random();
    res_t e, o;
    alu_op_e op;
    logic [31:0] d1, d2;
    for (int i = 0; i < 60; i++) begin
      op = alu_op_e'($urandom_range(0, 15));
      d1 = rnd_val();
      d2 = ($urandom_range(0, 5) == 0) ? d1 : rnd_val();
      e = model(op, d1, d2, m_hi, m_lo);
      run_op(op, d1, d2, o);
      n_cmp++;
      if (o.lat !== e.lat || o.rdy_low !== e.rdy_low) begin
        n_bad++; $display("FAIL rnd_timing op=%0d: got lat=%0d rdy_low=%0d want %0d/%0d",
                          op, o.lat, o.rdy_low, e.lat, e.rdy_low);
      end
      n_cmp++;
      if (o.result !== e.result || o.flags !== e.flags) begin
        n_bad++; $display("FAIL rnd_result op=%0d %h,%h: got %h/%b want %h/%b",
                          op, d1, d2, o.result, o.flags, e.result, e.flags);
      end
      n_cmp++;
      if (o.hi !== e.hi || o.lo !== e.lo) begin
        n_bad++; $display("FAIL rnd_hilo op=%0d %h,%h: got %h/%h want %h/%h",
                          op, d1, d2, o.hi, o.lo, e.hi, e.lo);
      end
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic test_back_to_back();
    res_t pend;
    int idx;
    alu_op_e op;
    logic [31:0] d1, d2;
    pend = '{default: 0};
    @(negedge clk);
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
          n_bad++; $display("FAIL b2b%0d_vld: got vld=%b rdy=%b want 1/1", i, bus.out_valid, bus.in_ready);
        end
        n_cmp++;
        if (bus.result !== pend.result || bus.hi !== pend.hi || bus.lo !== pend.lo) begin
          n_bad++; $display("FAIL b2b%0d_data: got %h %h %h want %h %h %h", i,
                            bus.result, bus.hi, bus.lo, pend.result, pend.hi, pend.lo);
        end
      end
      if (i < 20) begin
        idx = $urandom_range(0, 11);
        op = alu_op_e'((idx < 8) ? idx : idx + 4);
        d1 = rnd_val(); d2 = rnd_val();
        pend = model(op, d1, d2, m_hi, m_lo);
        m_hi = pend.hi; m_lo = pend.lo;
        bus.in_valid = 1'b1; bus.op = op; bus.data1 = d1; bus.data2 = d2;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    res_t e, o;
    int saw;
    e = model(OP_MTHI, 32'h1234, 32'h0, m_hi, m_lo);
    run_op(OP_MTHI, 32'h1234, 32'h0, o);
    m_hi = e.hi; m_lo = e.lo;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_MULTU; bus.data1 = $urandom | 32'h1; bus.data2 = $urandom | 32'h1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_idle: got rdy=%b want 1", bus.in_ready); end
    saw = 0;
    repeat (40) begin if (bus.out_valid) saw++; @(negedge clk); end
    n_cmp++;
    if (saw !== 0) begin n_bad++; $display("FAIL flush_novld: got %0d pulses want 0", saw); end
    n_cmp++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      n_bad++; $display("FAIL flush_hilo: got %h/%h want %h/%h", bus.hi, bus.lo, m_hi, m_lo);
    end
    e = model(OP_MFHI, 32'h0, 32'h0, m_hi, m_lo);
    run_op(OP_MFHI, 32'h0, 32'h0, o);
    n_cmp++;
    if (o.result !== e.result || o.lat !== 1) begin
      n_bad++; $display("FAIL flush_mfhi: got %h lat=%0d want %h lat=1", o.result, o.lat, e.result);
    end
    // flush and in_valid together: nothing is accepted
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_ADD; bus.data1 = 32'h3; bus.data2 = 32'h4; bus.flush = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_rdy: got %b want 0", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_noacc: got vld=%b want 0", bus.out_valid); end
    // flush while a single-cycle result is being presented
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.flush = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_pend: got vld=%b want 0", bus.out_valid); end
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    res_t e, o;
    int saw;
    e = model(OP_MTHI, $urandom | 32'h1, 32'h0, m_hi, m_lo);
    run_op(OP_MTHI, e.hi, 32'h0, o);
    m_hi = e.hi;
    e = model(OP_MTLO, $urandom | 32'h1, 32'h0, m_hi, m_lo);
    run_op(OP_MTLO, e.lo, 32'h0, o);
    m_lo = e.lo;
    @(negedge clk);
`ifdef ALU_MD_DIV_EN
    bus.op = OP_DIV;
`else
    bus.op = OP_MULT;
`endif
    bus.in_valid = 1'b1; bus.data1 = $urandom | 32'h1; bus.data2 = $urandom | 32'h1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
      n_bad++; $display("FAIL rstmid_state: got vld=%b %h/%h want 0 0/0", bus.out_valid, bus.hi, bus.lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", bus.in_ready); end
    saw = 0;
    repeat (40) begin if (bus.out_valid) saw++; @(negedge clk); end
    n_cmp++;
    if (saw !== 0) begin n_bad++; $display("FAIL rstmid_novld: got %0d pulses want 0", saw); end
    e = model(OP_MFLO, 32'h0, 32'h0, m_hi, m_lo);
    run_op(OP_MFLO, 32'h0, 32'h0, o);
    n_cmp++;
    if (o.result !== e.result || o.lat !== e.lat) begin
      n_bad++; $display("FAIL rstmid_mflo: got %h lat=%0d want %h lat=%0d", o.result, o.lat, e.result, e.lat);
    end
  endtask

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = OP_ADD; bus.data1 = '0; bus.data2 = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
